// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end for an 8:1 select mux: holds an accepted word on the
// mux data inputs, steps the select code 0..7 and streams each settled mux output bit.
module mux_scan_serializer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic [7:0] mux_d,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   input  logic       mux_out,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_bit,
   output logic       ser_last,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_PRESENT
   } state_t;

   // Counter reload value: a zero count means "sample on the next edge".
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] mux_d_q, mux_d_d;
   logic       ser_bit_q, ser_bit_d;
   logic       ser_last_q, ser_last_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= 3'd0;
         cnt_q      <= 4'd0;
         mux_d_q    <= 8'd0;
         ser_bit_q  <= 1'b0;
         ser_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         mux_d_q    <= mux_d_d;
         ser_bit_q  <= ser_bit_d;
         ser_last_q <= ser_last_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      mux_d_d    = mux_d_q;
      ser_bit_d  = ser_bit_q;
      ser_last_d = ser_last_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               mux_d_d = in_data;
               sel_d   = 3'd0;
               cnt_d   = SETTLE_INIT;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               ser_bit_d  = mux_out;
               ser_last_d = (sel_q == 3'd7);
               state_d    = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            // Code 7 never wraps here; the next word restarts at 0 via IDLE.
            if (ser_ready) begin
               if (sel_q == 3'd7) begin
                  state_d = ST_IDLE;
               end else begin
                  sel_d   = sel_q + 3'd1;
                  cnt_d   = SETTLE_INIT;
                  state_d = ST_SETTLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign ser_valid = (state_q == ST_PRESENT);
   assign busy      = (state_q != ST_IDLE);
   assign mux_d     = mux_d_q;
   assign s0        = sel_q[0];
   assign s1        = sel_q[1];
   assign s2        = sel_q[2];
   assign ser_bit   = ser_bit_q;
   assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer with the 8:1 mux modelled as mux_d[{s2,s1,s0}];
// one instance at SETTLE=1 and one at SETTLE=3 share clock and reset.
module tb_mux_scan_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, in_ready;
   logic [7:0] in_data = 8'd0, mux_d;
   logic       s0, s1, s2, mux_out;
   logic       ser_valid, ser_ready = 1'b1, ser_bit, ser_last, busy;

   logic       in_valid3 = 1'b0, in_ready3;
   logic [7:0] in_data3 = 8'd0, mux_d3;
   logic       s0_3, s1_3, s2_3, mux_out3;
   logic       ser_valid3, ser_ready3 = 1'b1, ser_bit3, ser_last3, busy3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mux_out  = mux_d[{s2, s1, s0}];
   assign mux_out3 = mux_d3[{s2_3, s1_3, s0_3}];

   mux_scan_serializer #(.SETTLE(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mux_d(mux_d), .s0(s0), .s1(s1), .s2(s2), .mux_out(mux_out),
      .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit),
      .ser_last(ser_last), .busy(busy)
   );

   mux_scan_serializer #(.SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .mux_d(mux_d3), .s0(s0_3), .s1(s1_3), .s2(s2_3), .mux_out(mux_out3),
      .ser_valid(ser_valid3), .ser_ready(ser_ready3), .ser_bit(ser_bit3),
      .ser_last(ser_last3), .busy(busy3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drains one word from the SETTLE=1 instance; optionally stalls bit stall_bit for
   // stall_len cycles, or stops after stop_n handshakes.
   task automatic collect1(input int max_c, input int stop_n, input int stall_bit,
                           input int stall_len, output logic [7:0] bits,
                           output logic [7:0] lasts, output int n, output int cyc,
                           output logic [63:0] vh, output int held, output logic sel_ok);
      int c = 0;
      int stalled = 0;
      bits = 8'd0; lasts = 8'd0; n = 0; vh = 64'd0; held = 0; sel_ok = 1'b1;
      forever begin
         vh[c] = ser_valid;
         if (ser_valid) begin
            if (n == stall_bit && stalled < stall_len) begin
               ser_ready = 1'b0;
               stalled++;
            end else begin
               ser_ready = 1'b1;
            end
            if (n == stall_bit && ser_bit) held++;
            if ({s2, s1, s0} != 3'(n)) sel_ok = 1'b0;
            if (ser_ready && n < 8) begin
               bits[n]  = ser_bit;
               lasts[n] = ser_last;
               n++;
            end
         end
         if (!busy || c >= max_c) break;
         tick();
         c++;
         if (stop_n > 0 && n >= stop_n) break;
      end
      ser_ready = 1'b1;
      cyc = c;
   endtask

   task automatic collect3(input int max_c, output logic [7:0] bits, output logic [7:0] lasts,
                           output int cyc, output logic [63:0] vh, output logic sel_ok);
      int c = 0;
      int n = 0;
      bits = 8'd0; lasts = 8'd0; vh = 64'd0; sel_ok = 1'b1;
      forever begin
         vh[c] = ser_valid3;
         if (c < 32 && {s2_3, s1_3, s0_3} != 3'(c / 4)) sel_ok = 1'b0;
         if (ser_valid3 && n < 8) begin
            bits[n]  = ser_bit3;
            lasts[n] = ser_last3;
            n++;
         end
         if (!busy3 || c >= max_c) break;
         tick();
         c++;
      end
      cyc = c;
   endtask

   initial begin
      logic [7:0]  bits, lasts;
      int          n, cyc, held;
      logic [63:0] vh;
      logic        sel_ok, quiet;

      // Reset behaviour
      tick();
      tick();
      check("rst_in_ready_low", in_ready, 1'b0);
      rst = 1'b0;
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_ser_valid", ser_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_mux_d", mux_d, 8'h00);
      check("rst_sel", {s2, s1, s0}, 3'd0);
      check("rst_ser_bit_last", {ser_bit, ser_last}, 2'b00);
      check("rst_in_ready3", in_ready3, 1'b1);

      // Basic word, SETTLE=1
      in_data = 8'hA5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_mux_d", mux_d, 8'hA5);
      check("t1_sel0", {s2, s1, s0}, 3'd0);
      check("t1_busy", busy, 1'b1);
      collect1(40, 0, -1, 0, bits, lasts, n, cyc, vh, held, sel_ok);
      $display("basic word A5: bits=%02h lasts=%02h cycles=%0d", bits, lasts, cyc);
      check("t1_bits", bits, 8'hA5);
      check("t1_last", lasts, 8'h80);
      check("t1_count", n, 8);
      check("t1_cycles", cyc, 16);
      check("t1_valid_pattern", vh, 64'h0000_AAAA);
      check("t1_sel", sel_ok, 1'b1);
      check("t1_in_ready_after", in_ready, 1'b1);
      check("t1_mux_d_held", mux_d, 8'hA5);

      // Backpressure on the 3rd bit
      in_data = 8'h3C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      collect1(60, 0, 2, 5, bits, lasts, n, cyc, vh, held, sel_ok);
      $display("backpressure 3C: bits=%02h held=%0d cycles=%0d", bits, held, cyc);
      check("t2_bits", bits, 8'h3C);
      check("t2_last", lasts, 8'h80);
      check("t2_cycles", cyc, 21);
      check("t2_held", held, 6);
      check("t2_valid_pattern", vh, 64'h0015_57EA);
      check("t2_sel_held", sel_ok, 1'b1);

      // Settle length, SETTLE=3
      in_data3 = 8'h01; in_valid3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
      collect3(60, bits, lasts, cyc, vh, sel_ok);
      $display("settle3 01: bits=%02h cycles=%0d", bits, cyc);
      check("t3_bits", bits, 8'h01);
      check("t3_last", lasts, 8'h80);
      check("t3_cycles", cyc, 32);
      check("t3_valid_pattern", vh, 64'h8888_8888);
      check("t3_sel_steps", sel_ok, 1'b1);

      // Inputs held valid while busy
      in_data = 8'h00; in_valid = 1'b1;
      tick();
      in_data = 8'hFF;
      collect1(40, 0, -1, 0, bits, lasts, n, cyc, vh, held, sel_ok);
      $display("busy inputs 00: bits=%02h cycles=%0d", bits, cyc);
      check("t4_bits", bits, 8'h00);
      check("t4_cycles", cyc, 16);
      check("t4_not_sampled", mux_d, 8'h00);
      check("t4_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      check("t4_ff_accepted", mux_d, 8'hFF);
      check("t4_ff_busy", busy, 1'b1);
      collect1(40, 0, -1, 0, bits, lasts, n, cyc, vh, held, sel_ok);
      $display("busy inputs FF: bits=%02h cycles=%0d", bits, cyc);
      check("t4_ff_bits", bits, 8'hFF);
      check("t4_ff_cycles", cyc, 16);

      // Reset after the 4th bit
      in_data = 8'h5A; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      collect1(40, 4, -1, 0, bits, lasts, n, cyc, vh, held, sel_ok);
      $display("reset mid 5A: bits=%02h n=%0d", bits, n);
      check("t5_partial_n", n, 4);
      check("t5_partial_bits", bits[3:0], 4'hA);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("t5_ser_valid", ser_valid, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_sel", {s2, s1, s0}, 3'd0);
      check("t5_mux_d", mux_d, 8'h00);
      check("t5_in_ready", in_ready, 1'b1);
      quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ser_valid || busy) quiet = 1'b0;
      end
      check("t5_no_more_valid", quiet, 1'b1);
      in_data = 8'h81; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      collect1(40, 0, -1, 0, bits, lasts, n, cyc, vh, held, sel_ok);
      $display("after reset 81: bits=%02h cycles=%0d", bits, cyc);
      check("t5_next_bits", bits, 8'h81);
      check("t5_next_last", lasts, 8'h80);
      check("t5_next_cycles", cyc, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
